// File: rtl/addsub_block_accumulator.sv
// Sums BLK_LEN signed adder/subtractor results per block and presents the block sum on a valid/ready output.
// Optional build macro ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module addsub_block_accumulator #(
   parameter int ACC_W   = 24,
   parameter int BLK_LEN = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_m,
   input  logic             in_co,
   input  logic [15:0]      in_s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf
);

   localparam int CNT_W = $clog2(BLK_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_LEN);
`ifdef ACC_SAT_EN
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;
   logic             out_ovf_q, out_ovf_d;

   logic [17:0]      mag;
   logic [17:0]      v;
   logic [ACC_W:0]   sum;
   logic             step_ovf;
   logic [ACC_W-1:0] acc_step;
   logic [CNT_W-1:0] cnt_inc;
   logic             accept;

   // in_m=1 with in_co=0 means in_s is the magnitude of a negative difference
   always_comb begin
      mag = {2'b00, in_s};
      if (!in_m) begin
         v = {1'b0, in_co, in_s};
      end else if (in_co) begin
         v = mag;
      end else begin
         v = ~mag + 18'd1;
      end
   end

   // acc_q is always zero in IDLE, so the first accept of a block reduces to a load
   always_comb begin
      sum      = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-17){v[17]}}, v};
      step_ovf = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef ACC_SAT_EN
      if (step_ovf) begin
         acc_step = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         acc_step = sum[ACC_W-1:0];
      end
`else
      acc_step = sum[ACC_W-1:0];
`endif
      cnt_inc = cnt_q + 1'b1;
   end

   assign in_ready = (state_q != DONE);
   assign accept   = in_valid & in_ready & ~clr;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_ovf_d   = out_ovf_q;
      if (clr) begin
         state_d     = IDLE;
         acc_d       = '0;
         cnt_d       = '0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc_d = acc_step;
                  cnt_d = cnt_inc;
                  ovf_d = ovf_q | step_ovf;
                  if (cnt_inc == CNT_LAST) begin
                     state_d     = DONE;
                     out_valid_d = 1'b1;
                     out_sum_d   = acc_step;
                     out_ovf_d   = ovf_q | step_ovf;
                  end else begin
                     state_d = ACCUM;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d     = IDLE;
                  acc_d       = '0;
                  cnt_d       = '0;
                  ovf_d       = 1'b0;
                  out_valid_d = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_ovf   = out_ovf_q;

endmodule
